ahb_sram_ctrl: RTL and testbench

AHB-Lite slave that drives four 8K×8 single-port synchronous SRAM banks as one 32 KB, 32-bit-wide memory, acting as the initiator on the SRAM pin interface (cs_n/wen/oen/Addr/Wdata/Data). Sits between the AHB interconnect and the SRAM macros in the sramc subsystem. Writes complete with zero wait states; reads take one wait state, covering the SRAM's registered read output.

---
 rtl/sramc_pkg.sv | 28 ++
 rtl/sramc_lane_dec.sv | 44 ++++
 rtl/ahb_sram_ctrl.sv | 134 +++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sramc_pkg.sv
// sramc_pkg: shared types and constants for the AHB-Lite to SRAM controller.
//   - sramc_state_e : controller FSM states
//   - HTRANS_* / HSIZE_* : AHB encodings
//   - SRAMC_AW / SRAMC_LANES : SRAM word-address width and byte-lane count
package sramc_pkg;

  localparam int unsigned SRAMC_AW    = 13;
  localparam int unsigned SRAMC_LANES = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdIssue,
    StRdData,
    StErr1,
    StErr2
  } sramc_state_e;

endpackage

// File: rtl/sramc_lane_dec.sv
// sramc_lane_dec: combinational byte-lane decoder for one AHB transfer.
// Config macro: SRAMC_ERR_RESP_EN -- when defined, oversize and misaligned transfers
// are flagged illegal; otherwise they are coerced to an aligned access.
// Ports:
//   hsize_i     : AHB transfer size
//   addr_lo_i   : haddr[1:0]
//   lane_mask_o : one bit per byte lane / SRAM bank touched by the transfer
//   illegal_o   : transfer must be answered with an ERROR response
module sramc_lane_dec
  import sramc_pkg::*;
(
  input  logic [2:0]             hsize_i,
  input  logic [1:0]             addr_lo_i,
  output logic [SRAMC_LANES-1:0] lane_mask_o,
  output logic                   illegal_o
);

  always_comb begin
    lane_mask_o = 4'b1111;
    illegal_o   = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: lane_mask_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: begin
        // addr_lo_i[0] is dropped, which forces the halfword aligned
        lane_mask_o = 4'b0011 << {addr_lo_i[1], 1'b0};
`ifdef SRAMC_ERR_RESP_EN
        illegal_o   = addr_lo_i[0];
`endif
      end
      HSIZE_WORD: begin
`ifdef SRAMC_ERR_RESP_EN
        illegal_o = (addr_lo_i != 2'b00);
`endif
      end
      default: begin
        // Sizes above a word: error, or a plain word access
`ifdef SRAMC_ERR_RESP_EN
        illegal_o = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite slave driving four 8Kx8 synchronous SRAM banks as one
// 32 KB, 32-bit memory. Writes: zero wait states. Reads: one wait state.
// Config macro: SRAMC_ERR_RESP_EN enables ERROR responses for illegal transfers.
// Ports:
//   clk_i, rst_ni             : clock, synchronous active-low reset
//   hsel_i .. hready_i        : AHB-Lite slave inputs (only haddr_i[14:0] used)
//   hreadyout_o, hresp_o,
//   hrdata_o                  : AHB-Lite slave outputs
//   sram_cs_n_o, sram_wen_o,
//   sram_oen_o                : per-bank active-low strobes (bank i = byte lane i)
//   sram_addr_o               : shared word address
//   sram_wdata_o, sram_rdata_i: SRAM data, lane i <-> bank i
module ahb_sram_ctrl
  import sramc_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   hsel_i,
  input  logic [1:0]             htrans_i,
  input  logic                   hwrite_i,
  input  logic [2:0]             hsize_i,
  input  logic [31:0]            haddr_i,
  input  logic [31:0]            hwdata_i,
  input  logic                   hready_i,
  output logic                   hreadyout_o,
  output logic                   hresp_o,
  output logic [31:0]            hrdata_o,
  output logic [SRAMC_LANES-1:0] sram_cs_n_o,
  output logic [SRAMC_LANES-1:0] sram_wen_o,
  output logic [SRAMC_LANES-1:0] sram_oen_o,
  output logic [SRAMC_AW-1:0]    sram_addr_o,
  output logic [31:0]            sram_wdata_o,
  input  logic [31:0]            sram_rdata_i
);

  sramc_state_e state_q, state_d;
  logic [SRAMC_AW-1:0]    addr_q, addr_d;
  logic [SRAMC_LANES-1:0] mask_q, mask_d;

  logic                   accept;
  logic [SRAMC_LANES-1:0] dec_mask;
  logic                   dec_illegal;

  logic unused_inputs;
  assign unused_inputs = ^{haddr_i[31:15], htrans_i[0]};

  // NONSEQ and SEQ are the only transfer types with bit 1 set
  assign accept = hsel_i & hready_i & htrans_i[1];

  sramc_lane_dec u_lane_dec (
    .hsize_i     (hsize_i),
    .addr_lo_i   (haddr_i[1:0]),
    .lane_mask_o (dec_mask),
    .illegal_o   (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    unique case (state_q)
      StRdIssue: state_d = StRdData;
      StErr1:    state_d = StErr2;
      default: begin
        // StIdle, StWr, StRdData, StErr2 all finish with hreadyout high,
        // so a new address phase may be taken here
        if (accept) begin
          addr_d = haddr_i[14:2];
          mask_d = dec_mask;
          if (dec_illegal) begin
            state_d = StErr1;
          end else if (hwrite_i) begin
            state_d = StWr;
          end else begin
            state_d = StRdIssue;
          end
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

  assign sram_addr_o = addr_q;

  // Strobes come only from state_q/mask_q, never straight from the AHB inputs
  always_comb begin
    hreadyout_o  = 1'b1;
    hresp_o      = 1'b0;
    hrdata_o     = '0;
    sram_cs_n_o  = '1;
    sram_wen_o   = '1;
    sram_oen_o   = '1;
    sram_wdata_o = '0;
    unique case (state_q)
      StWr: begin
        sram_cs_n_o  = ~mask_q;
        sram_wen_o   = ~mask_q;
        sram_wdata_o = hwdata_i;
      end
      StRdIssue: begin
        sram_cs_n_o = ~mask_q;
        sram_oen_o  = ~mask_q;
        hreadyout_o = 1'b0;
      end
      StRdData: hrdata_o = sram_rdata_i;
      StErr1: begin
        hresp_o     = 1'b1;
        hreadyout_o = 1'b0;
      end
      StErr2:  hresp_o = 1'b1;
      default: ;
    endcase
    // A write or read cycle that coincides with reset must not touch the SRAM
    if (!rst_ni) begin
      sram_cs_n_o = '1;
      sram_wen_o  = '1;
      sram_oen_o  = '1;
    end
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: self-checking bench for ahb_sram_ctrl. Drives pipelined AHB
// transfers (directed then random) and compares against a word-array memory model.
module tb_ahb_sram_ctrl;
  import sramc_pkg::*;

`ifdef SRAMC_ERR_RESP_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [3:0]  sram_cs_n;
  logic [3:0]  sram_wen;
  logic [3:0]  sram_oen;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  always #5 clk = ~clk;

  // Single slave on the bus: its own ready is the bus ready
  assign hready = hreadyout;

  ahb_sram_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .hsel_i       (hsel),
    .htrans_i     (htrans),
    .hwrite_i     (hwrite),
    .hsize_i      (hsize),
    .haddr_i      (haddr),
    .hwdata_i     (hwdata),
    .hready_i     (hready),
    .hreadyout_o  (hreadyout),
    .hresp_o      (hresp),
    .hrdata_o     (hrdata),
    .sram_cs_n_o  (sram_cs_n),
    .sram_wen_o   (sram_wen),
    .sram_oen_o   (sram_oen),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata)
  );

  // Four 8Kx8 synchronous banks with registered read output
  logic [7:0] bank_mem [4][8192];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!sram_cs_n[i]) begin
        if (!sram_wen[i]) bank_mem[i][sram_addr] <= sram_wdata[8*i +: 8];
        else if (!sram_oen[i]) sram_rdata[8*i +: 8] <= bank_mem[i][sram_addr];
      end
    end
  end

  // Reference memory, one 32-bit word per SRAM word address
  logic [31:0] ref_mem [8192];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_lanes(input logic [2:0] sz, input logic [31:0] a);
    if (sz == 3'd0) return 4'b0001 << a[1:0];
    if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit ref_illegal(input logic [2:0] sz, input logic [31:0] a);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] lanes);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (lanes[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Transfer currently in its data phase
  bit          p_v = 1'b0;
  bit          p_wr = 1'b0;
  bit          p_err = 1'b0;
  logic [3:0]  p_lanes = '0;
  logic [12:0] p_wa = '0;
  logic [31:0] p_wd = '0;

  // Called just after a rising edge: presents a new address phase, completes the
  // previous transfer's data phase and checks it.
  task automatic step(input bit sel, input logic [1:0] tr, input bit wr, input logic [2:0] sz,
                      input logic [31:0] ad, input logic [31:0] wd);
    int waits = 0;
    bit exp_wait;
    hsel   = sel;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = ad;
    hwdata = p_wd;
    exp_wait = p_v && (p_err || !p_wr);
    @(negedge clk);
    while (!hreadyout && waits < 4) begin
      if (waits == 0 && p_v && !p_err) begin
        check_val("rd_issue_cs_n", 32'(sram_cs_n), 32'(4'(~p_lanes)));
        check_val("rd_issue_oen", 32'(sram_oen), 32'(4'(~p_lanes)));
        check_val("rd_issue_wen", 32'(sram_wen), 32'hF);
        check_val("rd_issue_addr", 32'(sram_addr), 32'(p_wa));
      end else begin
        check_val("wait_cs_n", 32'(sram_cs_n), 32'hF);
      end
      check_val("wait_hresp", 32'(hresp), 32'(p_v && p_err));
      waits++;
      @(negedge clk);
    end
    check_val("wait_states", 32'(waits), 32'(exp_wait));
    check_val("hresp", 32'(hresp), 32'(p_v && p_err));
    if (p_v && !p_err && !p_wr) begin
      check_val("hrdata", hrdata & byte_mask(p_lanes), ref_mem[p_wa] & byte_mask(p_lanes));
      check_val("rd_data_cs_n", 32'(sram_cs_n), 32'hF);
    end else begin
      check_val("hrdata_zero", hrdata, 32'h0);
      if (p_v && p_wr && !p_err) begin
        check_val("wr_cs_n", 32'(sram_cs_n), 32'(4'(~p_lanes)));
        check_val("wr_wen", 32'(sram_wen), 32'(4'(~p_lanes)));
        check_val("wr_addr", 32'(sram_addr), 32'(p_wa));
        check_val("wr_wdata", sram_wdata, p_wd);
        for (int i = 0; i < 4; i++) if (p_lanes[i]) ref_mem[p_wa][8*i +: 8] = p_wd[8*i +: 8];
      end else begin
        check_val("idle_cs_n", 32'(sram_cs_n), 32'hF);
      end
    end
    @(posedge clk);
    #1;
    p_v     = sel && tr[1];
    p_wr    = wr;
    p_err   = ErrEn && ref_illegal(sz, ad);
    p_lanes = ref_lanes(sz, ad);
    p_wa    = ad[14:2];
    p_wd    = wd;
  endtask

  task automatic idle_step();
    step(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] win_addr(input int k, input logic [1:0] lo);
    int wi = (k < 16) ? k : (8192 - 32 + k);
    return {17'($urandom), 13'(wi), lo};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_hreadyout"}, 32'(hreadyout), 32'h1);
    check_val({tag, "_hresp"}, 32'(hresp), 32'h0);
    check_val({tag, "_hrdata"}, hrdata, 32'h0);
    check_val({tag, "_cs_n"}, 32'(sram_cs_n), 32'hF);
    check_val({tag, "_wen"}, 32'(sram_wen), 32'hF);
    check_val({tag, "_oen"}, 32'(sram_oen), 32'hF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    hsize  = 3'd0;
    haddr  = '0;
    hwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check_val("reset_addr", 32'(sram_addr), 32'h0);
    check_val("reset_wdata", sram_wdata, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Selected IDLE transfers: zero-wait OKAY
    step(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
    step(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h10, 32'h0);

    // Fill the address window used by the rest of the run
    for (int k = 0; k < 32; k++) step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, win_addr(k, 2'b00),
                                      $urandom);

    // Word write/read, byte write into lane 3, word read back
    step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0010, 32'hDEAD_BEEF);
    step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0);
    step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h0000_0013, 32'hAA00_0000);
    step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0);

    // Pipelined read, write, read-after-write
    step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0000, 32'h0);
    step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0000_0004, 32'h0BAD_F00D);
    step(1'b1, HTRANS_SEQ,    1'b0, HSIZE_WORD, 32'h0000_0004, 32'h0);

    // Misaligned halfword read, then misaligned halfword write
    step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 32'h0000_0001, 32'h0);
    step(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h0000_0001, 32'h1357_2468);
    step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0000, 32'h0);
    idle_step();

    // Randomized pipelined traffic over the window
    for (int n = 0; n < 400; n++) begin
      logic [2:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), sz,
           win_addr(int'($urandom_range(0, 31)), 2'($urandom_range(0, 3))), $urandom);
    end
    idle_step();
    idle_step();

    // Reset during a write cycle: the SRAM must not be written
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = 32'h10;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h1234_5678; rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_wr_cs_n", 32'(sram_cs_n), 32'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0000_0010, 32'h0);
    idle_step();

    // Reset during the read wait state
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 32'h4;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_rd_cs_n", 32'(sram_cs_n), 32'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_rst_rd");
    @(posedge clk);
    #1;
    idle_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
